// File: rtl/delay_ctrl.sv
// Programmable-length delay line with a RUN/FILL handshake that reports when a new delay is in effect.
// Optional build macro DELAY_CTRL_FLUSH_EN zeroes the line whenever a new delay is applied.
module delay_ctrl #(
    parameter int MAX_DELAY     = 16,
    parameter int WIDTH         = 1,
    parameter int DEFAULT_DELAY = 1,
    localparam int CW           = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             valid_out,
    input  logic [CW-1:0]    cfg_delay,
    input  logic             cfg_load,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             busy
);

    typedef enum logic {RUN, FILL} state_t;

    state_t          state;
    logic [CW-1:0]   d_cur;
    logic [CW-1:0]   fill_cnt;
    logic            ack_pend;
    logic            err_defer;
    logic [WIDTH-1:0] stage [MAX_DELAY];

    logic cfg_legal;
    logic start_fill;
    logic last_fill;
    logic flush;

    assign cfg_legal  = (cfg_delay != '0) && (cfg_delay <= CW'(MAX_DELAY));
    assign start_fill = (state == RUN) && cfg_load && cfg_legal;
    assign last_fill  = (fill_cnt == d_cur - CW'(1));

`ifdef DELAY_CTRL_FLUSH_EN
    assign flush = start_fill;
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_DELAY; i++) stage[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < MAX_DELAY; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d_in;
            for (int i = 1; i < MAX_DELAY; i++) stage[i] <= stage[i-1];
        end
    end

    always_comb begin
        d_out = '0;
        for (int i = 0; i < MAX_DELAY; i++)
            if (d_cur == CW'(i + 1)) d_out = stage[i];
    end

    // A load rejected on the very edge that ends a configured FILL would collide
    // with cfg_ack, so its error pulse is pushed out by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            d_cur     <= CW'(DEFAULT_DELAY);
            fill_cnt  <= '0;
            ack_pend  <= 1'b0;
            err_defer <= 1'b0;
            valid_out <= 1'b0;
            busy      <= 1'b1;
            cfg_ack   <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_ack   <= 1'b0;
            cfg_err   <= err_defer;
            err_defer <= 1'b0;
            case (state)
                RUN: begin
                    if (cfg_load) begin
                        if (cfg_legal) begin
                            d_cur     <= cfg_delay;
                            fill_cnt  <= '0;
                            ack_pend  <= 1'b1;
                            state     <= FILL;
                            valid_out <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    fill_cnt <= fill_cnt + CW'(1);
                    if (last_fill) begin
                        state     <= RUN;
                        valid_out <= 1'b1;
                        busy      <= 1'b0;
                        cfg_ack   <= ack_pend;
                        ack_pend  <= 1'b0;
                    end
                    if (cfg_load) begin
                        if (last_fill && ack_pend) err_defer <= 1'b1;
                        else                       cfg_err   <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_ctrl.sv
// Scoreboard bench for delay_ctrl: cfg_ack/cfg_err events are queued when loads are driven,
// d_out is checked against a history of sampled inputs at the expected delay.
module tb_delay_ctrl;
    localparam int MAXD = 16;
    localparam int W    = 8;
    localparam int DEFD = 1;
    localparam int CW   = $clog2(MAXD + 1);
    localparam int BIG  = 1 << 30;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  d_in = '0;
    logic [CW-1:0] cfg_delay = '0;
    logic          cfg_load = 1'b0;
    logic [W-1:0]  d_out;
    logic          valid_out, cfg_ack, cfg_err, busy;

    delay_ctrl #(.MAX_DELAY(MAXD), .WIDTH(W), .DEFAULT_DELAY(DEFD)) dut (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .d_out(d_out), .valid_out(valid_out),
        .cfg_delay(cfg_delay), .cfg_load(cfg_load), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int due; bit is_ack;} ev_t;
    ev_t evq[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int sent [0:4095];
    int exp_d = DEFD;
    int valid_from = BIG;
    int flush_lo = -1;
    int flush_hi = -1;
    bit prev_rst = 1'b0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    initial for (int i = 0; i < 4096; i++) sent[i] = 0;

    // Reference timeline: record sampled inputs and queue expected handshake events
    always @(posedge clk) begin
        cyc++;
        sent[cyc] = rst_n ? int'(d_in) : 0;
        if (rst_n && !prev_rst) valid_from = cyc + DEFD - 1;
        prev_rst = rst_n;
        if (rst_n && cfg_load) begin
            if (cyc > valid_from && cfg_delay >= 1 && cfg_delay <= MAXD) begin
                exp_d      = int'(cfg_delay);
                flush_lo   = cyc;
                flush_hi   = cyc + exp_d - 1;
                valid_from = cyc + exp_d;
                evq.push_back('{cyc + exp_d, 1'b1});
            end else begin
                evq.push_back('{cyc, 1'b0});
            end
        end
    end

    always @(negedge rst_n) begin
        for (int i = 0; i < 4096; i++) sent[i] = 0;
        evq.delete();
        exp_d      = DEFD;
        valid_from = BIG;
        flush_hi   = -1;
    end

    always @(negedge clk) begin
        bit ea, ee, ev;
        int idx, exp_out;
        ea = 1'b0;
        ee = 1'b0;
        foreach (evq[i])
            if (evq[i].due == cyc) begin
                if (evq[i].is_ack) ea = 1'b1;
                else               ee = 1'b1;
            end
        chk("cfg_ack", int'(cfg_ack), int'(ea));
        chk("cfg_err", int'(cfg_err), int'(ee));
        chk("ack_err_excl", int'(cfg_ack & cfg_err), 0);
        for (int i = evq.size() - 1; i >= 0; i--)
            if (evq[i].due <= cyc) evq.delete(i);
        ev = rst_n && (cyc >= valid_from);
        chk("valid_out", int'(valid_out), int'(ev));
        chk("busy", int'(busy), int'(!ev));
        idx = cyc - exp_d + 1;
        exp_out = (idx >= 0) ? sent[idx] : 0;
`ifdef DELAY_CTRL_FLUSH_EN
        if (cyc >= flush_lo && cyc <= flush_hi) exp_out = 0;
`endif
        chk("d_out", int'(d_out), exp_out);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            d_in = W'($urandom);
            tick();
        end
    endtask

    task automatic load(input int v, input logic [W-1:0] dv);
        cfg_delay = CW'(v);
        cfg_load  = 1'b1;
        d_in      = dv;
        tick();
        cfg_load  = 1'b0;
    endtask

    task automatic reset_checks();
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_ack", int'(cfg_ack), 0);
        chk("rst_err", int'(cfg_err), 0);
        chk("rst_d_out", int'(d_out), 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 reset_checks();
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d_in = ((i / 2) % 2 == 1) ? 8'hA5 : 8'h5A;
            tick();
        end
        load(4, W'($urandom));
        rnd_ticks(12);
        load(0, W'($urandom));
        rnd_ticks(3);
        load(17, W'($urandom));
        rnd_ticks(3);
        load(8, W'($urandom));
        rnd_ticks(2);
        load(2, W'($urandom));
        rnd_ticks(12);
        load(8, W'($urandom));
        rnd_ticks(12);
        load(8, W'($urandom));
        rnd_ticks(4);
        #2 rst_n = 1'b0;
        #1 reset_checks();
        repeat (2) tick();
        rst_n = 1'b1;
        rnd_ticks(6);
        d_in = 8'hFF;
        repeat (20) tick();
        load(3, 8'hFF);
        repeat (4) tick();
        rnd_ticks(6);
        load(16, W'($urandom));
        rnd_ticks(20);
        load(1, W'($urandom));
        rnd_ticks(6);
        chk("evq_empty", evq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
